weight_tile_bank: RTL and testbench



---
 rtl/weight_tile_bank.sv | 208 ++++++++++++++++++++
 tb/tb_weight_tile_bank.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_bank.sv
// weight_tile_bank: multi-buffer (ping-pong) weight store between the weight
// loader and the MAC array. One buffer fills while another drains; each
// buffer tracks its own length and full flag.

// Per-lane read output register: holds one weight element of the read beat.
module weight_tile_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Capture the lane element when the read side loads a new beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else if (load) q <= d;
  end

endmodule

module weight_tile_bank #(
  parameter int TILE_WIDTH   = 256,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_TILES    = 4,
  parameter int BUFFER_COUNT = 2,
  localparam int LANES = TILE_WIDTH / DATA_WIDTH,
  localparam int BW    = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
  localparam int LW    = $clog2(MAX_TILES + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_start,
  input  logic [BW-1:0]               wr_buf,
  input  logic [LW-1:0]               wr_len,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [TILE_WIDTH-1:0]       wr_data,
  output logic                        wr_done,
  input  logic                        rd_start,
  input  logic [BW-1:0]               rd_buf,
  input  logic                        rd_keep,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [LANES*DATA_WIDTH-1:0] rd_data,
  output logic                        rd_last,
  output logic                        rd_done,
  output logic [BUFFER_COUNT-1:0]     buf_full,
  output logic                        cmd_err
);

  localparam int DEPTH = BUFFER_COUNT * MAX_TILES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Latched command: target buffer and its tile count.
  typedef struct packed {
    logic [BW-1:0] bsel;
    logic [LW-1:0] len;
  } cmd_t;

  state_t                  wr_state, rd_state;
  cmd_t                    wr_cmd, rd_cmd;
  logic                    rd_keep_q;
  logic [LW-1:0]           wr_idx, rd_idx;
  logic [LW-1:0]           buf_len [BUFFER_COUNT];
  logic [TILE_WIDTH-1:0]   mem [DEPTH];

  // Flat tile address: buffers are laid out back to back, MAX_TILES each.
  function automatic logic [AW-1:0] tile_addr(input logic [BW-1:0] b, input logic [LW-1:0] i);
    return AW'(32'(b) * MAX_TILES + 32'(i));
  endfunction

  // Command qualification. A read wins a same-cycle collision on one buffer.
  logic wr_buf_ok, wr_len_ok, rd_buf_ok;
  logic rd_accept, rd_reject, wr_accept, wr_reject;
  logic wr_fire, wr_last, rd_load, lane_load;

  assign wr_buf_ok = 32'(wr_buf) < BUFFER_COUNT;
  assign rd_buf_ok = 32'(rd_buf) < BUFFER_COUNT;
  assign wr_len_ok = (wr_len != '0) && (32'(wr_len) <= MAX_TILES);

  assign rd_accept = (rd_state == IDLE) && rd_start && rd_buf_ok && buf_full[rd_buf] &&
                     !((wr_state == ACTIVE) && (wr_cmd.bsel == rd_buf));
  assign rd_reject = (rd_state == IDLE) && rd_start && !rd_accept;

  assign wr_accept = (wr_state == IDLE) && wr_start && wr_buf_ok && wr_len_ok && !buf_full[wr_buf] &&
                     !((rd_state == ACTIVE) && (rd_cmd.bsel == wr_buf)) &&
                     !(rd_accept && (rd_buf == wr_buf));
  assign wr_reject = (wr_state == IDLE) && wr_start && !wr_accept;

  // Ready is pure state so there is no combinational path from wr_valid.
  assign wr_ready = (wr_state == ACTIVE);
  assign wr_fire  = wr_ready && wr_valid;
  assign wr_last  = (wr_idx == wr_cmd.len - 1'b1);

  // Output register refills whenever it is empty or being consumed.
  assign rd_load   = (rd_state == ACTIVE) && (rd_idx < rd_cmd.len) && (!rd_valid || rd_ready);
  // First beat loads on the accepting edge so it is valid one cycle after rd_start.
  assign lane_load = rd_accept || rd_load;

  logic [AW-1:0]                      rd_addr;
  logic [LANES-1:0][DATA_WIDTH-1:0]   tile_lanes;
  logic [LANES-1:0][DATA_WIDTH-1:0]   out_lanes;

  assign rd_addr    = rd_accept ? tile_addr(rd_buf, '0) : tile_addr(rd_cmd.bsel, rd_idx);
  assign tile_lanes = mem[rd_addr];
  assign rd_data    = out_lanes;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    weight_tile_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (lane_load),
      .d       (tile_lanes[g]),
      .q       (out_lanes[g])
    );
  end

  // Tile storage: written one beat per accepted write handshake, never reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[tile_addr(wr_cmd.bsel, wr_idx)] <= wr_data;
  end

  // Write FSM, read FSM, per-buffer flags/lengths and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state  <= IDLE;
      rd_state  <= IDLE;
      wr_cmd    <= '0;
      rd_cmd    <= '0;
      rd_keep_q <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      cmd_err   <= 1'b0;
      buf_full  <= '0;
      for (int i = 0; i < BUFFER_COUNT; i++) buf_len[i] <= '0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      // Both sides rejecting in one cycle still gives a single pulse.
      cmd_err <= wr_reject || rd_reject;

      case (wr_state)
        IDLE: begin
          if (wr_accept) begin
            wr_cmd   <= '{bsel: wr_buf, len: wr_len};
            wr_idx   <= '0;
            wr_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (wr_valid) begin
            if (wr_last) begin
              wr_done                <= 1'b1;
              buf_full[wr_cmd.bsel]  <= 1'b1;
              buf_len[wr_cmd.bsel]   <= wr_cmd.len;
              wr_idx                 <= '0;
              wr_state               <= IDLE;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        default: wr_state <= IDLE;
      endcase

      case (rd_state)
        IDLE: begin
          if (rd_accept) begin
            rd_cmd    <= '{bsel: rd_buf, len: buf_len[rd_buf]};
            rd_keep_q <= rd_keep;
            rd_valid  <= 1'b1;
            rd_last   <= (buf_len[rd_buf] == LW'(1));
            rd_idx    <= LW'(1);
            rd_state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (rd_load) begin
            rd_valid <= 1'b1;
            rd_last  <= (rd_idx == rd_cmd.len - 1'b1);
            rd_idx   <= rd_idx + 1'b1;
          end else if (rd_valid && rd_ready) begin
            // Only the final beat is consumed without a refill.
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_last) begin
              rd_done  <= 1'b1;
              if (!rd_keep_q) buf_full[rd_cmd.bsel] <= 1'b0;
              rd_idx   <= '0;
              rd_state <= IDLE;
            end
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_tile_bank.sv
// Scoreboard bench for weight_tile_bank: stimulus pushes expected read beats,
// a negedge monitor compares every presented beat and counts status pulses.
module tb_weight_tile_bank;

  logic        clk, reset_n;
  logic        wr_start, wr_valid, wr_ready, wr_done;
  logic [0:0]  wr_buf, rd_buf;
  logic [2:0]  wr_len;
  logic [31:0] wr_data, rd_data;
  logic        rd_start, rd_keep, rd_valid, rd_ready, rd_last, rd_done;
  logic [1:0]  buf_full;
  logic        cmd_err;

  weight_tile_bank #(.TILE_WIDTH(32), .DATA_WIDTH(8), .MAX_TILES(4), .BUFFER_COUNT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_start(wr_start), .wr_buf(wr_buf), .wr_len(wr_len), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
    .rd_start(rd_start), .rd_buf(rd_buf), .rd_keep(rd_keep), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .rd_done(rd_done),
    .buf_full(buf_full), .cmd_err(cmd_err)
  );

  typedef struct { logic [31:0] data; logic last; } beat_t;
  beat_t       exp_q[$];
  logic [31:0] mmem [2][4];
  int          mlen [2];

  int checks, errors;
  int n_wr_done, n_rd_done, n_err, n_hs;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on every presented beat, pop on handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_done) n_wr_done++;
      if (rd_done) n_rd_done++;
      if (cmd_err) n_err++;
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got data %0h last %0b, expected no beat", rd_data, rd_last);
        end else begin
          if (rd_data !== exp_q[0].data || rd_last !== exp_q[0].last) begin
            errors++;
            $display("FAIL rd_beat: got %0h/%0b, expected %0h/%0b",
                     rd_data, rd_last, exp_q[0].data, exp_q[0].last);
          end
          if (rd_ready) begin
            void'(exp_q.pop_front());
            n_hs++;
          end
        end
      end
    end
  end

  task automatic push_read(input int b);
    for (int i = 0; i < mlen[b]; i++) exp_q.push_back('{mmem[b][i], i == mlen[b] - 1});
  endtask

  task automatic wr_issue(input int b, input int len);
    @(posedge clk); #1;
    wr_start = 1; wr_buf = 1'(b); wr_len = 3'(len);
    @(posedge clk); #1;
    wr_start = 0;
  endtask

  task automatic rd_issue(input int b, input logic keep);
    @(posedge clk); #1;
    rd_start = 1; rd_buf = 1'(b); rd_keep = keep;
    @(posedge clk); #1;
    rd_start = 0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int b, input int len, input logic [31:0] base);
    int p, n;
    logic [31:0] d;
    p = n_wr_done;
    wr_issue(b, len);
    for (int i = 0; i < len; i++) begin
      d = base + 32'(i) * 32'h04040404;
      wr_valid = 1; wr_data = d;
      n = 0;
      while (!wr_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      mmem[b][i] = d;
    end
    wr_valid = 0;
    @(posedge clk); #1;
    mlen[b] = len;
    chk("wr_done_count", n_wr_done - p, 1);
  endtask

  task automatic wait_rd_done(input int p);
    int n;
    n = 0;
    while (n_rd_done == p && n < 100) begin @(posedge clk); #1; n++; end
    chk("rd_done_count", n_rd_done - p, 1);
  endtask

  task automatic do_read(input int b, input logic keep);
    int p;
    p = n_rd_done;
    push_read(b);
    rd_issue(b, keep);
    chk("rd_first_valid", rd_valid, 1);
    wait_rd_done(p);
    chk("rd_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int p, e, h;
    logic [6:0] pat;
    checks = 0; errors = 0;
    n_wr_done = 0; n_rd_done = 0; n_err = 0; n_hs = 0;
    mlen[0] = 0; mlen[1] = 0;
    reset_n = 0; wr_start = 0; wr_buf = 0; wr_len = 0; wr_valid = 0; wr_data = 0;
    rd_start = 0; rd_buf = 0; rd_keep = 0; rd_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_buf_full", buf_full, 0);
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_pulses", {wr_done, rd_done, cmd_err, rd_last}, 0);
    reset_n = 1;

    // Basic fill and drain with exact beat timing.
    do_write(0, 4, 32'h03020100);
    chk("basic_full_after_write", buf_full, 2'b01);
    p = n_rd_done;
    push_read(0);
    rd_issue(0, 0);
    chk("basic_valid_t1", rd_valid, 1);
    chk("basic_lane0", rd_data[7:0], 8'h00);
    chk("basic_lane1", rd_data[15:8], 8'h01);
    chk("basic_lane3", rd_data[31:24], 8'h03);
    repeat (3) @(posedge clk);
    #1;
    chk("basic_last_beat3", {rd_valid, rd_last}, 2'b11);
    @(posedge clk); #1;
    chk("basic_rd_done", {rd_done, rd_valid}, 2'b10);
    wait_rd_done(p);
    chk("basic_full_after_read", buf_full, 2'b00);
    chk("basic_no_err", n_err, 0);

    // Ping-pong: write buf1 while draining buf0.
    do_write(0, 2, 32'hA3A2A1A0);
    e = n_err;
    fork
      do_write(1, 3, 32'h13121110);
      do_read(0, 0);
    join
    chk("pingpong_full", buf_full, 2'b10);
    chk("pingpong_no_err", n_err - e, 0);

    // Backpressure on a len3 buffer (keep so buf1 stays loaded).
    h = n_hs; p = n_rd_done;
    pat = 7'b1101001;  // bit k = rd_ready in cycle k: 1,0,0,1,0,1,1
    push_read(1);
    rd_issue(1, 1);
    for (int k = 0; k < 7; k++) begin
      rd_ready = pat[k];
      @(posedge clk); #1;
    end
    rd_ready = 1;
    wait_rd_done(p);
    chk("bp_handshakes", n_hs - h, 3);
    chk("bp_keep_full", buf_full, 2'b10);

    // Rejections.
    e = n_err;
    rd_issue(0, 0);
    settle();
    chk("rej_rd_empty_err", n_err - e, 1);
    chk("rej_rd_empty_valid", rd_valid, 0);
    e = n_err;
    wr_issue(1, 2);
    settle();
    chk("rej_wr_full_err", n_err - e, 1);
    chk("rej_wr_full_ready", wr_ready, 0);
    e = n_err;
    wr_issue(0, 0);
    settle();
    chk("rej_len0_err", n_err - e, 1);
    chk("rej_len0_ready", wr_ready, 0);
    e = n_err;
    wr_issue(0, 5);
    settle();
    chk("rej_len5_err", n_err - e, 1);
    chk("rej_len_state", {wr_ready, buf_full}, 3'b010);

    // Write aimed at the buffer under a stalled read.
    e = n_err; p = n_rd_done;
    push_read(1);
    rd_ready = 0;
    rd_issue(1, 1);
    wr_issue(1, 2);
    settle();
    chk("rej_wr_reading_err", n_err - e, 1);
    chk("rej_wr_reading_ready", wr_ready, 0);
    rd_ready = 1;
    wait_rd_done(p);

    // Same-cycle read and write on full buf1: read wins, one error pulse.
    e = n_err; p = n_rd_done;
    push_read(1);
    fork
      wr_issue(1, 2);
      rd_issue(1, 1);
    join
    chk("same_cycle_rd_valid", rd_valid, 1);
    wait_rd_done(p);
    settle();
    chk("same_cycle_err_once", n_err - e, 1);
    chk("same_cycle_state", {wr_ready, buf_full}, 3'b010);

    // Keep/reuse: another keep read, then a consuming read.
    do_read(1, 1);
    chk("keep_still_full", buf_full[1], 1);
    do_read(1, 0);
    chk("keep0_clears", buf_full, 2'b00);

    // Reset in the middle of a write.
    do_write(1, 1, 32'h55AA55AA);
    chk("pre_reset_full", buf_full, 2'b10);
    p = n_wr_done;
    wr_issue(0, 4);
    wr_valid = 1; wr_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    wr_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    wr_valid = 0;
    #2 reset_n = 0;
    #1;
    chk("async_reset_full", buf_full, 0);
    chk("async_reset_ctrl", {wr_ready, rd_valid, rd_last, wr_done, rd_done, cmd_err}, 0);
    chk("async_reset_data", rd_data, 0);
    @(posedge clk); #1;
    reset_n = 1;
    mlen[0] = 0; mlen[1] = 0;
    chk("reset_no_wr_done", n_wr_done - p, 0);
    e = n_err;
    rd_issue(0, 0);
    settle();
    chk("post_reset_rd0_err", n_err - e, 1);
    e = n_err;
    rd_issue(1, 0);
    settle();
    chk("post_reset_rd1_err", n_err - e, 1);
    do_write(0, 4, 32'h83828180);
    chk("post_reset_full", buf_full, 2'b01);
    do_read(0, 0);
    chk("post_reset_empty", buf_full, 2'b00);

    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
